execute_stage_module: RTL and testbench
=======================================

# execute_stage_module

Execute stage of the 8-bit MIPS pipeline, directly upstream of the data memory stage. It takes decoded operands and control from the decode stage, computes the ALU result (or a load/store address), and registers `ans_ex`, `B_Bypass`, `RW_ex` and the memory control bits that the data memory stage consumes. Single-cycle ops complete in one clock. `MUL` runs on an 8-cycle shift-add FSM and stalls the front of the pipeline while it runs.

## Interface
- No parameters. Data width is fixed at 8 bits and the register-address width at 5 bits.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_dec`  in  1  decode stage presents a valid instruction.
- `A_dec`  in  8  operand 1 (rs value).
- `B_dec`  in  8  operand 2 (rt value); also store data.
- `imm_dec`  in  8  immediate.
- `imm_sel_dec`  in  1  1 = ALU operand 2 is `imm_dec`; 0 = ALU operand 2 is `B_dec`.
- `alu_op_dec`  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
- `RW_dec`  in  5  destination register; 0 = no writeback.
- `mem_en_dec`, `mem_rw_dec`, `mem_mux_sel_dec`  in  1 each  memory controls, passed through.
- `ans_ex`  out  8  registered ALU result or memory address.
- `B_Bypass`  out  8  registered `B_dec` (store data).
- `RW_ex`  out  5  registered destination.
- `mem_en_ex`, `mem_rw_ex`, `mem_mux_sel_ex`  out  1 each  registered memory controls.
- `zero_ex`  out  1  registered flag: (result == 0).
- `carry_ex`  out  1  registered flag: ADD carry-out, or SUB borrow (A < op2 unsigned); 0 for all other ops.
- `stall`  out  1  high while the MUL FSM is busy; upstream must hold its inputs.

## Operation
- Operand 2 is `op2 = imm_sel_dec ? imm_dec : B_dec`.
- Arithmetic is unsigned modulo 2^8. ADD/SUB use a 9-bit internal sum, and bit 8 drives `carry_ex`.
- SLL and SRL shift `A_dec` by `op2[2:0]` with zero fill.
- **Bubble** means these outputs are all 0: `RW_ex`, `mem_en_ex`, `mem_rw_ex`, `mem_mux_sel_ex`, `ans_ex`, `zero_ex`, `carry_ex`. `B_Bypass` is also 0 in a bubble.
- FSM states:
  - **IDLE**
    - Inputs are sampled at every posedge.
    - `valid_dec`=0: register a bubble.
    - Valid non-MUL op: register the result, flags and pass-through controls.
    - Valid MUL: capture `mcand`=`A_dec`, `mplr`=`op2`, `acc`=0, `cnt`=0. Also capture `RW_dec`, the three memory controls and `B_dec`. Register a bubble, then go to BUSY.
  - **BUSY**
    - Inputs are ignored; a bubble is held on the outputs.
    - Each posedge: if `mplr[0]`, then `acc` += `mcand`. Then `mcand` <<= 1, `mplr` >>= 1, `cnt`++.
    - On the edge where `cnt`==7, register the final sum on `ans_ex` (the low 8 bits of the product) and the captured controls. `zero_ex` reflects the product; `carry_ex`=0. Go to IDLE.
- `stall` = (state == BUSY), decoded combinationally from the state register.
- Reset (any cycle, including mid-BUSY):
  - State goes to IDLE.
  - All outputs and internal registers clear to 0.
  - An in-flight MUL is discarded and no result is ever emitted.
- Reset has priority over every other event at the same edge.

## Timing
- Reset values: every output is 0, including `stall`.
- Single-cycle ops: inputs sampled at edge E are visible on the outputs after edge E. Latency is 1 cycle and throughput is 1 instruction per cycle.
- MUL accepted at edge E0:
  - `stall` is high from after E0 until after E8, i.e. 8 cycles.
  - The product is visible after E8 for exactly one cycle, then normal issue resumes.
  - The first post-MUL instruction is sampled at E9.
- Handshake: upstream must hold `*_dec` stable while `stall`=1. The block never samples inputs in BUSY. `valid_dec` is likewise ignored in BUSY.
- Back-to-back MULs: the second MUL is accepted at E9, with no extra gap cycle.
- Outputs change only on posedge. There is no combinational path from any `*_dec` input to any output.

## Test plan
- **Reset then single-cycle ops.**
  - Assert reset 2 cycles: all outputs are 0 and `stall`=0.
  - ADD A=0x7F, B=0x01, `RW_dec`=3: the next cycle gives `ans_ex`=0x80, `carry_ex`=0, `zero_ex`=0, `RW_ex`=3.
- **ADD and SUB carry/zero flags.**
  - ADD 0xFF+0x01: `ans_ex`=0x00, `carry_ex`=1, `zero_ex`=1.
  - SUB 0x05−0x07: `ans_ex`=0xFE, `carry_ex`=1.
- **Immediate and shifts.**
  - `imm_sel_dec`=1, imm=0x0B, SLL A=0x81 (shift = 3): `ans_ex`=0x08.
  - SRL A=0x81 by 3: `ans_ex`=0x10.
  - Load-address case: `mem_en`=1, `mem_mux_sel`=1 pass through with `ans_ex`=A+imm.
- **MUL A=0x0D × B=0x0B.**
  - `stall` is high for exactly 8 cycles, with bubbles (`RW_ex`=0) throughout.
  - Then `ans_ex`=0x8F for one cycle with the captured `RW_ex`.
  - The input changes made during the stall are ignored.
- **MUL overflow and back-to-back.**
  - 0x10×0x10 gives `ans_ex`=0x00, `zero_ex`=1.
  - The next MUL, 0x03×0x05, is issued at E9 and yields 0x0F after its own 8 stall cycles.
- **Reset mid-MUL.**
  - Assert reset on the 4th BUSY cycle: `stall`=0 and all outputs are 0 on the next cycle.
  - No product appears afterwards, and an ADD issued next completes in 1 cycle.

Source files
------------

// File: rtl/execute_stage_module.sv
// Execute stage of the 8-bit MIPS pipeline: single-cycle ALU plus an 8-cycle
// shift-add multiplier that stalls the front end while it runs.
module execute_stage_module (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_dec,
  input  logic [7:0] A_dec,
  input  logic [7:0] B_dec,
  input  logic [7:0] imm_dec,
  input  logic       imm_sel_dec,
  input  logic [2:0] alu_op_dec,
  input  logic [4:0] RW_dec,
  input  logic       mem_en_dec,
  input  logic       mem_rw_dec,
  input  logic       mem_mux_sel_dec,
  output logic [7:0] ans_ex,
  output logic [7:0] B_Bypass,
  output logic [4:0] RW_ex,
  output logic       mem_en_ex,
  output logic       mem_rw_ex,
  output logic       mem_mux_sel_ex,
  output logic       zero_ex,
  output logic       carry_ex,
  output logic       stall
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t     state_reg, state_next;
  logic [7:0] mcand_reg, mcand_next;
  logic [7:0] mplr_reg, mplr_next;
  logic [7:0] acc_reg, acc_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [4:0] rw_cap_reg, rw_cap_next;
  logic       en_cap_reg, en_cap_next;
  logic       mrw_cap_reg, mrw_cap_next;
  logic       mux_cap_reg, mux_cap_next;
  logic [7:0] b_cap_reg, b_cap_next;

  logic [7:0] ans_next, b_next;
  logic [4:0] rw_next;
  logic       en_next, mrw_next, mux_next, zero_next, carry_next;

  logic [7:0] op2;
  logic [8:0] sum9;
  logic [7:0] alu_res;
  logic       alu_carry;
  logic [7:0] acc_sum;

  assign op2 = imm_sel_dec ? imm_dec : B_dec;

  // Bit 8 of the 9-bit sum is the ADD carry-out or, for SUB, the borrow.
  always_comb begin
    sum9      = 9'd0;
    alu_res   = 8'd0;
    alu_carry = 1'b0;
    case (alu_op_dec)
      OP_ADD: begin
        sum9      = {1'b0, A_dec} + {1'b0, op2};
        alu_res   = sum9[7:0];
        alu_carry = sum9[8];
      end
      OP_SUB: begin
        sum9      = {1'b0, A_dec} - {1'b0, op2};
        alu_res   = sum9[7:0];
        alu_carry = sum9[8];
      end
      OP_AND:  alu_res = A_dec & op2;
      OP_OR:   alu_res = A_dec | op2;
      OP_XOR:  alu_res = A_dec ^ op2;
      OP_SLL:  alu_res = A_dec << op2[2:0];
      OP_SRL:  alu_res = A_dec >> op2[2:0];
      default: alu_res = 8'd0;
    endcase
  end

  assign acc_sum = acc_reg + (mplr_reg[0] ? mcand_reg : 8'd0);

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    mplr_next    = mplr_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    rw_cap_next  = rw_cap_reg;
    en_cap_next  = en_cap_reg;
    mrw_cap_next = mrw_cap_reg;
    mux_cap_next = mux_cap_reg;
    b_cap_next   = b_cap_reg;
    // Bubble unless a result is produced this edge.
    ans_next     = 8'd0;
    b_next       = 8'd0;
    rw_next      = 5'd0;
    en_next      = 1'b0;
    mrw_next     = 1'b0;
    mux_next     = 1'b0;
    zero_next    = 1'b0;
    carry_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_dec) begin
          if (alu_op_dec == OP_MUL) begin
            mcand_next   = A_dec;
            mplr_next    = op2;
            acc_next     = 8'd0;
            cnt_next     = 3'd0;
            rw_cap_next  = RW_dec;
            en_cap_next  = mem_en_dec;
            mrw_cap_next = mem_rw_dec;
            mux_cap_next = mem_mux_sel_dec;
            b_cap_next   = B_dec;
            state_next   = BUSY;
          end else begin
            ans_next   = alu_res;
            b_next     = B_dec;
            rw_next    = RW_dec;
            en_next    = mem_en_dec;
            mrw_next   = mem_rw_dec;
            mux_next   = mem_mux_sel_dec;
            zero_next  = (alu_res == 8'd0);
            carry_next = alu_carry;
          end
        end
      end
      BUSY: begin
        acc_next   = acc_sum;
        mcand_next = mcand_reg << 1;
        mplr_next  = mplr_reg >> 1;
        cnt_next   = cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          ans_next   = acc_sum;
          b_next     = b_cap_reg;
          rw_next    = rw_cap_reg;
          en_next    = en_cap_reg;
          mrw_next   = mrw_cap_reg;
          mux_next   = mux_cap_reg;
          zero_next  = (acc_sum == 8'd0);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      mcand_reg      <= 8'd0;
      mplr_reg       <= 8'd0;
      acc_reg        <= 8'd0;
      cnt_reg        <= 3'd0;
      rw_cap_reg     <= 5'd0;
      en_cap_reg     <= 1'b0;
      mrw_cap_reg    <= 1'b0;
      mux_cap_reg    <= 1'b0;
      b_cap_reg      <= 8'd0;
      ans_ex         <= 8'd0;
      B_Bypass       <= 8'd0;
      RW_ex          <= 5'd0;
      mem_en_ex      <= 1'b0;
      mem_rw_ex      <= 1'b0;
      mem_mux_sel_ex <= 1'b0;
      zero_ex        <= 1'b0;
      carry_ex       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mcand_reg      <= mcand_next;
      mplr_reg       <= mplr_next;
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      rw_cap_reg     <= rw_cap_next;
      en_cap_reg     <= en_cap_next;
      mrw_cap_reg    <= mrw_cap_next;
      mux_cap_reg    <= mux_cap_next;
      b_cap_reg      <= b_cap_next;
      ans_ex         <= ans_next;
      B_Bypass       <= b_next;
      RW_ex          <= rw_next;
      mem_en_ex      <= en_next;
      mem_rw_ex      <= mrw_next;
      mem_mux_sel_ex <= mux_next;
      zero_ex        <= zero_next;
      carry_ex       <= carry_next;
    end
  end

  assign stall = (state_reg == BUSY);

endmodule

// File: tb/tb_execute_stage_module.sv
// Scoreboard bench for execute_stage_module: the driver pushes the expected
// per-cycle output vector, a monitor pops and compares one vector per clock.
module tb_execute_stage_module;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_dec = 1'b0;
  logic [7:0] A_dec = 8'd0, B_dec = 8'd0, imm_dec = 8'd0;
  logic       imm_sel_dec = 1'b0;
  logic [2:0] alu_op_dec = 3'd0;
  logic [4:0] RW_dec = 5'd0;
  logic       mem_en_dec = 1'b0, mem_rw_dec = 1'b0, mem_mux_sel_dec = 1'b0;
  logic [7:0] ans_ex, B_Bypass;
  logic [4:0] RW_ex;
  logic       mem_en_ex, mem_rw_ex, mem_mux_sel_ex, zero_ex, carry_ex, stall;

  typedef struct {
    logic [7:0] ans;
    logic [7:0] b;
    logic [4:0] rw;
    logic       en, mrw, mux, zero, carry, stall;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  execute_stage_module dut (
    .clk(clk), .reset(reset), .valid_dec(valid_dec),
    .A_dec(A_dec), .B_dec(B_dec), .imm_dec(imm_dec), .imm_sel_dec(imm_sel_dec),
    .alu_op_dec(alu_op_dec), .RW_dec(RW_dec),
    .mem_en_dec(mem_en_dec), .mem_rw_dec(mem_rw_dec), .mem_mux_sel_dec(mem_mux_sel_dec),
    .ans_ex(ans_ex), .B_Bypass(B_Bypass), .RW_ex(RW_ex),
    .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex), .mem_mux_sel_ex(mem_mux_sel_ex),
    .zero_ex(zero_ex), .carry_ex(carry_ex), .stall(stall)
  );

  function automatic exp_t bubble(input logic st);
    exp_t e;
    e.ans = 8'd0; e.b = 8'd0; e.rw = 5'd0;
    e.en = 1'b0; e.mrw = 1'b0; e.mux = 1'b0;
    e.zero = 1'b0; e.carry = 1'b0; e.stall = st;
    return e;
  endfunction

  // Reference arithmetic on plain integers.
  function automatic exp_t ref_result(input int a, input int b, input int op2, input int op,
                                      input int rw, input logic en, input logic mrw,
                                      input logic mux);
    exp_t e;
    int   r;
    int   c;
    c = 0;
    case (op)
      0: begin r = (a + op2) % 256; c = (a + op2 > 255) ? 1 : 0; end
      1: begin r = (a - op2 + 256) % 256; c = (a < op2) ? 1 : 0; end
      2: r = a & op2;
      3: r = a | op2;
      4: r = a ^ op2;
      5: r = (a * (1 << (op2 % 8))) % 256;
      6: r = a / (1 << (op2 % 8));
      default: begin r = (a * op2) % 256; c = 0; end
    endcase
    e.ans = 8'(r); e.b = 8'(b); e.rw = 5'(rw);
    e.en = en; e.mrw = mrw; e.mux = mux;
    e.zero = (r == 0); e.carry = (c != 0); e.stall = 1'b0;
    return e;
  endfunction

  task automatic scramble_inputs();
    valid_dec       = 1'($urandom);
    A_dec           = 8'($urandom);
    B_dec           = 8'($urandom);
    imm_dec         = 8'($urandom);
    imm_sel_dec     = 1'($urandom);
    alu_op_dec      = 3'($urandom);
    RW_dec          = 5'($urandom);
    mem_en_dec      = 1'($urandom);
    mem_rw_dec      = 1'($urandom);
    mem_mux_sel_dec = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      scramble_inputs();
      q.push_back(bubble(1'b0));
    end
  endtask

  // abort_k > 0 asserts reset at the k-th edge after a MUL is accepted.
  task automatic drive_op(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] imm, input logic sel, input logic [2:0] op,
                          input logic [4:0] rw, input logic en, input logic mrw,
                          input logic mux, input int abort_k);
    int   op2;
    exp_t res;
    @(negedge clk);
    reset = 1'b0;
    valid_dec = v; A_dec = a; B_dec = b; imm_dec = imm; imm_sel_dec = sel;
    alu_op_dec = op; RW_dec = rw; mem_en_dec = en; mem_rw_dec = mrw; mem_mux_sel_dec = mux;
    op2 = sel ? int'(imm) : int'(b);
    res = ref_result(int'(a), int'(b), op2, int'(op), int'(rw), en, mrw, mux);
    if (!v) begin
      q.push_back(bubble(1'b0));
    end else if (op != 3'd7) begin
      q.push_back(res);
    end else begin
      q.push_back(bubble(1'b1));
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        scramble_inputs();
        if (k == abort_k) begin
          reset = 1'b1;
          q.push_back(bubble(1'b0));
          return;
        end
        if (k < 8) q.push_back(bubble(1'b1));
        else       q.push_back(res);
      end
    end
  endtask

  // Monitor: one vector per clock, sampled just after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (ans_ex !== e.ans || B_Bypass !== e.b || RW_ex !== e.rw ||
            mem_en_ex !== e.en || mem_rw_ex !== e.mrw || mem_mux_sel_ex !== e.mux ||
            zero_ex !== e.zero || carry_ex !== e.carry || stall !== e.stall) begin
          errors++;
          $display("FAIL out_cycle%0d got ans=%h b=%h rw=%0d en=%b rw=%b mux=%b z=%b c=%b st=%b want ans=%h b=%h rw=%0d en=%b rw=%b mux=%b z=%b c=%b st=%b",
                   cyc, ans_ex, B_Bypass, RW_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex,
                   zero_ex, carry_ex, stall, e.ans, e.b, e.rw, e.en, e.mrw, e.mux,
                   e.zero, e.carry, e.stall);
        end else begin
          $display("cycle %0d ans=%h rw=%0d z=%b c=%b stall=%b ok", cyc, ans_ex, RW_ex,
                   zero_ex, carry_ex, stall);
        end
      end
    end
  end

  initial begin
    int drain;
    do_reset(2);
    drive_op(1, 8'h7F, 8'h01, 8'h00, 0, 3'd0, 5'd3, 0, 0, 0, 0);
    drive_op(1, 8'hFF, 8'h01, 8'h00, 0, 3'd0, 5'd4, 0, 0, 0, 0);
    drive_op(1, 8'h05, 8'h07, 8'h00, 0, 3'd1, 5'd5, 0, 0, 0, 0);
    drive_op(1, 8'h81, 8'h00, 8'h0B, 1, 3'd5, 5'd6, 0, 0, 0, 0);
    drive_op(1, 8'h81, 8'h00, 8'h0B, 1, 3'd6, 5'd6, 0, 0, 0, 0);
    drive_op(1, 8'h20, 8'h99, 8'h05, 1, 3'd0, 5'd8, 1, 0, 1, 0);
    drive_op(1, 8'h30, 8'h5A, 8'h04, 1, 3'd0, 5'd0, 1, 1, 0, 0);
    drive_op(0, 8'h12, 8'h34, 8'h56, 0, 3'd2, 5'd9, 1, 1, 1, 0);
    drive_op(1, 8'h0D, 8'h0B, 8'h00, 0, 3'd7, 5'd7, 0, 0, 0, 0);
    drive_op(1, 8'h10, 8'h10, 8'h00, 0, 3'd7, 5'd10, 0, 0, 0, 0);
    drive_op(1, 8'h03, 8'h05, 8'h00, 0, 3'd7, 5'd11, 0, 0, 0, 0);
    drive_op(1, 8'h0D, 8'h0B, 8'h00, 0, 3'd7, 5'd12, 0, 0, 0, 4);
    drive_op(1, 8'h01, 8'h02, 8'h00, 0, 3'd0, 5'd13, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 99) < 15) ? 3'd7 : 3'($urandom_range(0, 6));
      if ($urandom_range(0, 99) < 3) begin
        do_reset(1);
      end else begin
        drive_op(($urandom_range(0, 99) < 85), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom), op, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 99) < 10) ? int'($urandom_range(1, 8)) : 0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    valid_dec = 1'b0;
    drain = 0;
    while (q.size() > 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
